// File: rtl/d_unit_pkg.sv
// Shared decode constants and helpers for the fetch, decode and hazard units.
// Defining D_UNIT_BNE_EN adds bne to the decoded instruction subset.
package d_unit_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    typedef enum logic [1:0] {
        PCSRC_PC4    = 2'b00,
        PCSRC_BRANCH = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_JR     = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        FWD_FILE     = 2'b00,
        FWD_E        = 2'b01,
        FWD_M        = 2'b10,
        FWD_FILE_ALT = 2'b11
    } fwd_sel_e;

    typedef enum logic [3:0] {
        INSTR_NOP,
        INSTR_ADDU,
        INSTR_SUBU,
        INSTR_ORI,
        INSTR_LUI,
        INSTR_LW,
        INSTR_SW,
        INSTR_BEQ,
        INSTR_BNE,
        INSTR_J,
        INSTR_JAL,
        INSTR_JR
    } instr_e;

    // Anything outside the supported subset falls through to INSTR_NOP.
    function automatic instr_e decode_instr(input logic [31:0] ir);
        instr_e kind;
        kind = INSTR_NOP;
        case (ir[31:26])
            OP_SPECIAL: begin
                case (ir[5:0])
                    FN_ADDU: kind = INSTR_ADDU;
                    FN_SUBU: kind = INSTR_SUBU;
                    FN_JR:   kind = INSTR_JR;
                    default: kind = INSTR_NOP;
                endcase
            end
            OP_ORI:  kind = INSTR_ORI;
            OP_LUI:  kind = INSTR_LUI;
            OP_LW:   kind = INSTR_LW;
            OP_SW:   kind = INSTR_SW;
            OP_BEQ:  kind = INSTR_BEQ;
`ifdef D_UNIT_BNE_EN
            OP_BNE:  kind = INSTR_BNE;
`endif
            OP_J:    kind = INSTR_J;
            OP_JAL:  kind = INSTR_JAL;
            default: kind = INSTR_NOP;
        endcase
        return kind;
    endfunction

    function automatic logic [31:0] fwd_mux(input logic [1:0] sel,
                                            input logic [31:0] file_val,
                                            input logic [31:0] e_val,
                                            input logic [31:0] m_val);
        logic [31:0] result;
        case (sel)
            FWD_E:   result = e_val;
            FWD_M:   result = m_val;
            default: result = file_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/d_unit_grf.sv
// 32x32 general register file: two combinational read ports with write-back
// bypass, one write port, $0 hard-wired to zero.
module grf_D
    import d_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != 5'd0)) begin
            regs_d[wa] = wd;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // A write landing this edge is visible to decode in the same cycle.
    always_comb begin
        rd1 = regs_q[ra1];
        if (ra1 == 5'd0) begin
            rd1 = '0;
        end else if (we && (wa == ra1)) begin
            rd1 = wd;
        end

        rd2 = regs_q[ra2];
        if (ra2 == 5'd0) begin
            rd2 = '0;
        end else if (we && (wa == ra2)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/d_unit.sv
// Decode stage: register read with forwarding, extender, branch compare,
// next-PC selection and the D/E pipeline register. D_UNIT_BNE_EN enables bne.
module d_unit
    import d_unit_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IRD,
    input  logic [31:0] PC4D,
    input  logic        StallD,
    input  logic        RegWrite_W,
    input  logic [4:0]  WA_W,
    input  logic [31:0] WD_W,
    input  logic [1:0]  FwdSel_RS,
    input  logic [1:0]  FwdSel_RT,
    input  logic [31:0] FwdData_E,
    input  logic [31:0] FwdData_M,
    output logic [31:0] NPC,
    output logic [1:0]  PCsrc,
    output logic        Branch,
    output logic [31:0] RS_D_OUT,
    output logic [31:0] IRE,
    output logic [31:0] PC4E,
    output logic [31:0] RS_E,
    output logic [31:0] RT_E,
    output logic [31:0] EXT_E
);

    instr_e      instr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [15:0] imm16;
    logic [31:0] rf_rs;
    logic [31:0] rf_rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] ext_val;
    logic [31:0] br_target;
    logic [31:0] npc;
    pcsrc_e      pcsrc;
    logic        branch_taken;

    logic [31:0] ire_q, ire_d;
    logic [31:0] pc4e_q, pc4e_d;
    logic [31:0] rs_e_q, rs_e_d;
    logic [31:0] rt_e_q, rt_e_d;
    logic [31:0] ext_e_q, ext_e_d;

    assign instr   = decode_instr(IRD);
    assign rs_addr = IRD[25:21];
    assign rt_addr = IRD[20:16];
    assign imm16   = IRD[15:0];

    grf_D u_grf (
        .clk   (Clk),
        .rst_n (Reset),
        .ra1   (rs_addr),
        .ra2   (rt_addr),
        .we    (RegWrite_W),
        .wa    (WA_W),
        .wd    (WD_W),
        .rd1   (rf_rs),
        .rd2   (rf_rt)
    );

    assign rs_val   = fwd_mux(FwdSel_RS, rf_rs, FwdData_E, FwdData_M);
    assign rt_val   = fwd_mux(FwdSel_RT, rf_rt, FwdData_E, FwdData_M);
    assign RS_D_OUT = rs_val;

    always_comb begin
        case (instr)
            INSTR_ORI:                        ext_val = {16'h0000, imm16};
            INSTR_LW, INSTR_SW, INSTR_BEQ,
            INSTR_BNE:                        ext_val = {{16{imm16[15]}}, imm16};
            INSTR_LUI:                        ext_val = {imm16, 16'h0000};
            default:                          ext_val = '0;
        endcase
    end

    assign br_target = PC4D + {{14{imm16[15]}}, imm16, 2'b00};

    // Branch targets are presented even when not taken; PCsrc alone tells fetch.
    always_comb begin
        branch_taken = 1'b0;
        pcsrc        = PCSRC_PC4;
        npc          = PC4D;
        case (instr)
            INSTR_BEQ: begin
                branch_taken = (rs_val == rt_val);
                npc          = br_target;
                if (branch_taken) begin
                    pcsrc = PCSRC_BRANCH;
                end
            end
            INSTR_BNE: begin
                branch_taken = (rs_val != rt_val);
                npc          = br_target;
                if (branch_taken) begin
                    pcsrc = PCSRC_BRANCH;
                end
            end
            INSTR_J, INSTR_JAL: begin
                pcsrc = PCSRC_JUMP;
                npc   = {PC4D[31:28], IRD[25:0], 2'b00};
            end
            INSTR_JR: begin
                pcsrc = PCSRC_JR;
                npc   = rs_val;
            end
            default: begin
                pcsrc = PCSRC_PC4;
            end
        endcase
    end

    assign NPC    = npc;
    assign PCsrc  = pcsrc;
    assign Branch = branch_taken;

    always_comb begin
        if (StallD) begin
            ire_d   = '0;
            pc4e_d  = '0;
            rs_e_d  = '0;
            rt_e_d  = '0;
            ext_e_d = '0;
        end else begin
            ire_d   = IRD;
            pc4e_d  = PC4D;
            rs_e_d  = rs_val;
            rt_e_d  = rt_val;
            ext_e_d = ext_val;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ire_q   <= '0;
            pc4e_q  <= '0;
            rs_e_q  <= '0;
            rt_e_q  <= '0;
            ext_e_q <= '0;
        end else begin
            ire_q   <= ire_d;
            pc4e_q  <= pc4e_d;
            rs_e_q  <= rs_e_d;
            rt_e_q  <= rt_e_d;
            ext_e_q <= ext_e_d;
        end
    end

    assign IRE   = ire_q;
    assign PC4E  = pc4e_q;
    assign RS_E  = rs_e_q;
    assign RT_E  = rt_e_q;
    assign EXT_E = ext_e_q;

endmodule

// File: tb/tb_d_unit.sv
// Directed, table-driven self-checking bench for the decode unit d_unit.
module tb_d_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] IRD;
    logic [31:0] PC4D;
    logic        StallD;
    logic        RegWrite_W;
    logic [4:0]  WA_W;
    logic [31:0] WD_W;
    logic [1:0]  FwdSel_RS;
    logic [1:0]  FwdSel_RT;
    logic [31:0] FwdData_E;
    logic [31:0] FwdData_M;
    logic [31:0] NPC;
    logic [1:0]  PCsrc;
    logic        Branch;
    logic [31:0] RS_D_OUT;
    logic [31:0] IRE;
    logic [31:0] PC4E;
    logic [31:0] RS_E;
    logic [31:0] RT_E;
    logic [31:0] EXT_E;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic [31:0] ird;
        logic [31:0] pc4d;
        logic [1:0]  fsel_rs;
        logic [1:0]  fsel_rt;
        logic [31:0] fwd_e;
        logic [31:0] fwd_m;
        logic        chk_npc;
        logic [31:0] exp_npc;
        logic [1:0]  exp_pcsrc;
        logic        exp_branch;
        logic [31:0] exp_rs;
        logic [31:0] exp_ext;
    } vec_t;

    vec_t vecs[$];

    d_unit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .IRD        (IRD),
        .PC4D       (PC4D),
        .StallD     (StallD),
        .RegWrite_W (RegWrite_W),
        .WA_W       (WA_W),
        .WD_W       (WD_W),
        .FwdSel_RS  (FwdSel_RS),
        .FwdSel_RT  (FwdSel_RT),
        .FwdData_E  (FwdData_E),
        .FwdData_M  (FwdData_M),
        .NPC        (NPC),
        .PCsrc      (PCsrc),
        .Branch     (Branch),
        .RS_D_OUT   (RS_D_OUT),
        .IRE        (IRE),
        .PC4E       (PC4E),
        .RS_E       (RS_E),
        .RT_E       (RT_E),
        .EXT_E      (EXT_E)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
        RegWrite_W = 1'b1;
        WA_W       = addr;
        WD_W       = data;
        tick();
        RegWrite_W = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        IRD       = v.ird;
        PC4D      = v.pc4d;
        FwdSel_RS = v.fsel_rs;
        FwdSel_RT = v.fsel_rt;
        FwdData_E = v.fwd_e;
        FwdData_M = v.fwd_m;
        #1;
    endtask

    function automatic vec_t mk(string name, logic [31:0] ird, logic [31:0] pc4d,
                                logic [1:0] frs, logic [1:0] frt,
                                logic [31:0] fe, logic [31:0] fm,
                                logic cn, logic [31:0] npc, logic [1:0] pcs,
                                logic br, logic [31:0] rs, logic [31:0] ext);
        vec_t v;
        v.name = name; v.ird = ird; v.pc4d = pc4d; v.fsel_rs = frs; v.fsel_rt = frt;
        v.fwd_e = fe; v.fwd_m = fm; v.chk_npc = cn; v.exp_npc = npc;
        v.exp_pcsrc = pcs; v.exp_branch = br; v.exp_rs = rs; v.exp_ext = ext;
        return v;
    endfunction

    initial begin
        logic        bne_br;
        logic [1:0]  bne_pcs;
        logic [31:0] bne_ext;

        checks = 0;
        errors = 0;

`ifdef D_UNIT_BNE_EN
        bne_br  = 1'b1;
        bne_pcs = 2'b01;
        bne_ext = 32'hFFFF_FFFF;
`else
        bne_br  = 1'b0;
        bne_pcs = 2'b00;
        bne_ext = 32'h0000_0000;
`endif

        // $1=0x11, $2=0x22, $31=0 are set up before the table runs.
        vecs.push_back(mk("beq_taken",   32'h1021FFFF, 32'h00003004, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h00003000, 2'b01, 1'b1, 32'h11, 32'hFFFFFFFF));
        vecs.push_back(mk("beq_nottkn",  32'h1022FFFF, 32'h00003004, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,        2'b00, 1'b0, 32'h11, 32'hFFFFFFFF));
        vecs.push_back(mk("jal",         32'h0C000C00, 32'h00003010, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'h00003000, 2'b10, 1'b0, 32'h0,  32'h0));
        vecs.push_back(mk("jr_fwd_m",    32'h03E00008, 32'h00003020, 2'b10, 2'b00, 32'h0, 32'h0000301C, 1'b1, 32'h0000301C, 2'b11, 1'b0, 32'h0000301C, 32'h0));
        vecs.push_back(mk("j_highpc",    32'h0BFFFFFF, 32'hA0000004, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'hAFFFFFFC, 2'b10, 1'b0, 32'h0,  32'h0));
        vecs.push_back(mk("beq_wrap",    32'h10008000, 32'h00000004, 2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 32'hFFFE0004, 2'b01, 1'b1, 32'h0,  32'hFFFF8000));
        vecs.push_back(mk("beq_fwd_e",   32'h1022FFFF, 32'h00003004, 2'b01, 2'b00, 32'h22, 32'h0, 1'b1, 32'h00003000, 2'b01, 1'b1, 32'h22, 32'hFFFFFFFF));
        vecs.push_back(mk("beq_sel11",   32'h1022FFFF, 32'h00003004, 2'b11, 2'b11, 32'h22, 32'h22, 1'b0, 32'h0,       2'b00, 1'b0, 32'h11, 32'hFFFFFFFF));
        vecs.push_back(mk("bne",         32'h1422FFFF, 32'h00003004, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,        bne_pcs, bne_br, 32'h11, bne_ext));
        vecs.push_back(mk("unknown_op",  32'hFC000000, 32'h00003004, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0,  32'h0));
        vecs.push_back(mk("nop",         32'h00000000, 32'h00003008, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0,  32'h0));
        vecs.push_back(mk("subu_fwd_m",  32'h00222023, 32'h0000300C, 2'b10, 2'b00, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0, 2'b00, 1'b0, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk("ori_zext",    32'h3402FFFF, 32'h00003010, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0,  32'h0000FFFF));
        vecs.push_back(mk("lui",         32'h3C01ABCD, 32'h00003014, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0,  32'hABCD0000));
        vecs.push_back(mk("lw_sext",     32'h8C01FFF8, 32'h00003018, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0,  32'hFFFFFFF8));
        vecs.push_back(mk("sw_sext_pos", 32'hAC017FF0, 32'h0000301C, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,        2'b00, 1'b0, 32'h0,  32'h00007FF0));

        Reset      = 1'b0;
        IRD        = 32'h00200821;
        PC4D       = 32'h0;
        StallD     = 1'b0;
        RegWrite_W = 1'b0;
        WA_W       = 5'd0;
        WD_W       = 32'h0;
        FwdSel_RS  = 2'b00;
        FwdSel_RT  = 2'b00;
        FwdData_E  = 32'h0;
        FwdData_M  = 32'h0;

        tick();
        checkOutput("reset_IRE", IRE, 32'h0);
        checkOutput("reset_RS_E", RS_E, 32'h0);
        checkOutput("reset_EXT_E", EXT_E, 32'h0);
        checkOutput("reset_rd_r1", RS_D_OUT, 32'h0);
        Reset = 1'b1;

        // Register write then read into E stage.
        writeReg(5'd5, 32'h12345678);
        IRD = 32'h00A51821;
        PC4D = 32'h00003000;
        tick();
        checkOutput("addu_RS_E", RS_E, 32'h12345678);
        checkOutput("addu_RT_E", RT_E, 32'h12345678);
        checkOutput("addu_IRE", IRE, 32'h00A51821);
        checkOutput("addu_PC4E", PC4E, 32'h00003000);

        // Same-cycle write-back bypass of $8.
        IRD        = 32'h01004821;
        RegWrite_W = 1'b1;
        WA_W       = 5'd8;
        WD_W       = 32'hA5A5A5A5;
        #1;
        checkOutput("bypass_rs", RS_D_OUT, 32'hA5A5A5A5);
        tick();
        RegWrite_W = 1'b0;
        checkOutput("bypass_RS_E", RS_E, 32'hA5A5A5A5);
        #1;
        checkOutput("landed_r8", RS_D_OUT, 32'hA5A5A5A5);

        writeReg(5'd1, 32'h11);
        writeReg(5'd2, 32'h22);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            if (vecs[i].chk_npc) checkOutput({vecs[i].name, "_NPC"}, NPC, vecs[i].exp_npc);
            checkOutput({vecs[i].name, "_PCsrc"}, {30'h0, PCsrc}, {30'h0, vecs[i].exp_pcsrc});
            checkOutput({vecs[i].name, "_Branch"}, {31'h0, Branch}, {31'h0, vecs[i].exp_branch});
            checkOutput({vecs[i].name, "_RS"}, RS_D_OUT, vecs[i].exp_rs);
            tick();
            checkOutput({vecs[i].name, "_EXT_E"}, EXT_E, vecs[i].exp_ext);
            checkOutput({vecs[i].name, "_IRE"}, IRE, vecs[i].ird);
            checkOutput({vecs[i].name, "_RS_E"}, RS_E, vecs[i].exp_rs);
        end

        // Stall inserts a bubble while decode outputs keep tracking IRD.
        FwdSel_RS = 2'b00;
        FwdSel_RT = 2'b00;
        IRD       = 32'h1021FFFF;
        PC4D      = 32'h00003004;
        StallD    = 1'b1;
        #1;
        checkOutput("stall_PCsrc", {30'h0, PCsrc}, 32'h1);
        IRD = 32'h3402FFFF;
        tick();
        checkOutput("stall_IRE", IRE, 32'h0);
        checkOutput("stall_EXT_E", EXT_E, 32'h0);
        checkOutput("stall_PC4E", PC4E, 32'h0);
        StallD = 1'b0;
        tick();
        checkOutput("unstall_IRE", IRE, 32'h3402FFFF);
        checkOutput("unstall_EXT_E", EXT_E, 32'h0000FFFF);

        // Reset mid-write: the pending write to $5 must not land.
        RegWrite_W = 1'b1;
        WA_W       = 5'd5;
        WD_W       = 32'hFFFF0000;
        StallD     = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("rst_async_IRE", IRE, 32'h0);
        checkOutput("rst_async_RS_E", RS_E, 32'h0);
        checkOutput("rst_async_RT_E", RT_E, 32'h0);
        checkOutput("rst_async_PC4E", PC4E, 32'h0);
        checkOutput("rst_async_EXT_E", EXT_E, 32'h0);
        tick();
        RegWrite_W = 1'b0;
        StallD     = 1'b0;
        for (int r = 1; r < 32; r++) begin
            IRD = {6'h00, r[4:0], r[4:0], 16'h0821};
            #1;
            checkOutput($sformatf("rst_rs_r%0d", r), RS_D_OUT, 32'h0);
        end
        #3;
        Reset = 1'b1;

        // Write to $0 is dropped, even in the bypass path.
        IRD = 32'h00000821;
        writeReg(5'd0, 32'hFFFFFFFF);
        checkOutput("r0_after_write", RS_D_OUT, 32'h0);
        IRD = 32'h00A51821;
        #1;
        checkOutput("r5_after_reset", RS_D_OUT, 32'h0);

        // First edge after release loads normally.
        IRD  = 32'h34021234;
        PC4D = 32'h00004004;
        tick();
        checkOutput("post_rst_IRE", IRE, 32'h34021234);
        checkOutput("post_rst_EXT_E", EXT_E, 32'h00001234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
